// File: rtl/bus_sram_responder_pkg.sv
// Shared types and helpers for the bus SRAM responder.
// Contents: responder state encoding, bytes-per-word constant, address-window compare helper.
package bus_sram_responder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReadAddr,
    StReadData,
    StReadEnd,
    StWriteData,
    StError
  } state_e;

  localparam int unsigned WordBytesLog2 = 2;

  // True when addr lies in the window starting at base that spans 2**addr_bits words.
  // Only the tag bits above the word index and byte offset are compared.
  function automatic logic window_hit(logic [31:0] addr, logic [31:0] base,
                                      int unsigned addr_bits);
    logic [31:0] tag_mask;
    tag_mask = 32'hFFFF_FFFF << (addr_bits + WordBytesLog2);
    return (addr & tag_mask) == (base & tag_mask);
  endfunction

endpackage

// File: rtl/bus_sram_responder_if.sv
// Burst bus as seen by one responder.
// Request signals run master -> slave. The resp_* signals run slave -> master and are zero
// while the slave is not selected, so several slaves can be OR-combined onto the bus.
interface bus_sram_responder_if;
  logic        begin_transaction;
  logic        end_transaction;
  logic        read_not_write;
  logic        data_valid;
  logic        bus_error;
  logic [31:0] address_data;
  logic [3:0]  byte_enables;
  logic [7:0]  burst_size;

  logic        resp_end_transaction;
  logic        resp_data_valid;
  logic        resp_bus_error;
  logic [31:0] resp_address_data;

  modport master (
    output begin_transaction, end_transaction, read_not_write, data_valid, bus_error,
           address_data, byte_enables, burst_size,
    input  resp_end_transaction, resp_data_valid, resp_bus_error, resp_address_data
  );

  modport slave (
    input  begin_transaction, end_transaction, read_not_write, data_valid, bus_error,
           address_data, byte_enables, burst_size,
    output resp_end_transaction, resp_data_valid, resp_bus_error, resp_address_data
  );
endinterface

// File: rtl/bus_sram_byte_ram.sv
// Single-port synchronous RAM of 32-bit words with per-byte write strobes.
// Ports: clk_i clock; addr_i word address; be_i byte write strobes (0 = no write);
//        wdata_i write data; rdata_o word at addr_i, valid one cycle later (old data on write).
// Contents have no reset and survive a responder reset.
module bus_sram_byte_ram #(
  parameter int unsigned NrOfWords = 1024
) (
  input  logic                         clk_i,
  input  logic [$clog2(NrOfWords)-1:0] addr_i,
  input  logic [3:0]                   be_i,
  input  logic [31:0]                  wdata_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem_q [NrOfWords];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_sram_responder.sv
// Burst-bus slave that maps a word-addressed SRAM at BaseAddress.
// Ports: clk_i clock; rst_ni async active-low reset; bus_io slave side of the burst bus.
// Serves single and burst reads/writes, answers misaligned or out-of-window bursts with a
// one-cycle error + end response. All bus inputs are registered once and all outputs are
// registered; outputs stay zero unless this slave is responding.
module bus_sram_responder
  import bus_sram_responder_pkg::*;
#(
  parameter logic [31:0] BaseAddress = 32'h5000_0000,
  parameter int unsigned NrOfWords   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  bus_sram_responder_if.slave   bus_io
);

  localparam int unsigned AddrBits = $clog2(NrOfWords);
  // Wide enough that index + burst never wraps.
  localparam int unsigned SumBits  = (AddrBits > 8 ? AddrBits : 8) + 1;

  // Registered bus inputs.
  logic        begin_q, end_q, rnw_q, dv_in_q, err_in_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [7:0]  burst_q;

  state_e                state_q, state_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [AddrBits-1:0]   ptr_q, ptr_d;
  logic [3:0]            be_lat_q, be_lat_d;

  logic        out_end_q, out_end_d;
  logic        out_dv_q, out_dv_d;
  logic        out_err_q, out_err_d;
  logic [31:0] out_data_q, out_data_d;

  logic [AddrBits-1:0] word_idx, ram_addr;
  logic [SumBits-1:0]  last_word;
  logic                hit, bad_req, ram_we;
  logic [31:0]         ram_rdata;

  assign word_idx  = addr_q[AddrBits+1:2];
  assign last_word = SumBits'(word_idx) + SumBits'(burst_q);
  assign hit       = begin_q && window_hit(addr_q, BaseAddress, AddrBits);
  assign bad_req   = (addr_q[1:0] != 2'b00) || (last_word > SumBits'(NrOfWords - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    be_lat_d   = be_lat_q;
    ram_addr   = ptr_q;
    ram_we     = 1'b0;
    out_dv_d   = 1'b0;
    out_end_d  = 1'b0;
    out_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Issue the first read speculatively; it is only used if a read burst starts.
        ram_addr = word_idx;
        if (hit) begin
          if (bad_req) begin
            out_err_d = 1'b1;
            out_end_d = 1'b1;
            state_d   = StError;
          end else if (rnw_q) begin
            ptr_d   = word_idx + AddrBits'(1);
            cnt_d   = 9'(burst_q);
            state_d = StReadAddr;
          end else begin
            ptr_d    = word_idx;
            cnt_d    = 9'(burst_q) + 9'd1;
            be_lat_d = be_q;
            state_d  = StWriteData;
          end
        end
      end
      StReadAddr, StReadData: begin
        if (end_q || err_in_q) begin
          state_d = StIdle;
        end else begin
          // cnt_q counts words still to be presented after this one.
          out_dv_d = 1'b1;
          ptr_d    = ptr_q + AddrBits'(1);
          if (cnt_q == 9'd0) begin
            state_d = StReadEnd;
          end else begin
            cnt_d   = cnt_q - 9'd1;
            state_d = StReadData;
          end
        end
      end
      StReadEnd: begin
        out_end_d = 1'b1;
        state_d   = StIdle;
      end
      StWriteData: begin
        // cnt_q counts words still accepted; surplus beats are dropped.
        if (dv_in_q && cnt_q != 9'd0) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + AddrBits'(1);
          cnt_d  = cnt_q - 9'd1;
        end
        if (end_q || err_in_q) state_d = StIdle;
      end
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    out_data_d = out_dv_d ? ram_rdata : 32'h0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      begin_q    <= 1'b0;
      end_q      <= 1'b0;
      rnw_q      <= 1'b0;
      dv_in_q    <= 1'b0;
      err_in_q   <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      burst_q    <= 8'h0;
      state_q    <= StIdle;
      cnt_q      <= 9'd0;
      ptr_q      <= '0;
      be_lat_q   <= 4'h0;
      out_end_q  <= 1'b0;
      out_dv_q   <= 1'b0;
      out_err_q  <= 1'b0;
      out_data_q <= 32'h0;
    end else begin
      begin_q    <= bus_io.begin_transaction;
      end_q      <= bus_io.end_transaction;
      rnw_q      <= bus_io.read_not_write;
      dv_in_q    <= bus_io.data_valid;
      err_in_q   <= bus_io.bus_error;
      addr_q     <= bus_io.address_data;
      be_q       <= bus_io.byte_enables;
      burst_q    <= bus_io.burst_size;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      be_lat_q   <= be_lat_d;
      out_end_q  <= out_end_d;
      out_dv_q   <= out_dv_d;
      out_err_q  <= out_err_d;
      out_data_q <= out_data_d;
    end
  end

  bus_sram_byte_ram #(
    .NrOfWords(NrOfWords)
  ) u_ram (
    .clk_i  (clk_i),
    .addr_i (ram_addr),
    .be_i   (be_lat_q & {4{ram_we}}),
    .wdata_i(addr_q),
    .rdata_o(ram_rdata)
  );

  assign bus_io.resp_end_transaction = out_end_q;
  assign bus_io.resp_data_valid      = out_dv_q;
  assign bus_io.resp_bus_error       = out_err_q;
  assign bus_io.resp_address_data    = out_data_q;

endmodule
